// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared funct3 codes, arbiter states and lane masks for sram_port_arbiter
package sram_arb_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] LANE_B0   = 4'b0001;
  localparam logic [3:0] LANE_H_LO = 4'b0011;
  localparam logic [3:0] LANE_H_HI = 4'b1100;
  localparam logic [3:0] LANE_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB_ISSUE = 2'd1,
    WB_DATA  = 2'd2,
    WB_ACK   = 2'd3
  } arb_state_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    return (((f3 == F3_H) || (f3 == F3_HU)) && lsb[0]) || ((f3 == F3_W) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// rtl/sram_lane_align.sv - combinational RV32 store lane mask/replication and load extraction/extension
module sram_lane_align
  import sram_arb_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lsb,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_din,
  output logic        st_ok,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lsb,
  input  logic [31:0] ld_dout,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_wmask = '0;
    st_din   = st_wdata;
    st_ok    = 1'b0;
    case (st_funct3)
      F3_B: begin
        st_wmask = LANE_B0 << st_lsb;
        st_din   = {4{st_wdata[7:0]}};
        st_ok    = 1'b1;
      end
      F3_H: begin
        st_wmask = st_lsb[1] ? LANE_H_HI : LANE_H_LO;
        st_din   = {2{st_wdata[15:0]}};
        st_ok    = 1'b1;
      end
      F3_W: begin
        st_wmask = LANE_ALL;
        st_ok    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ld_dout[{ld_lsb, 3'b000} +: 8];
    half_sel = ld_lsb[1] ? ld_dout[31:16] : ld_dout[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'd0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = ld_dout;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - core/Wishbone arbiter for a 1-cycle sky130 SRAM macro
// Optional misalignment flag and store suppression under SRAM_ARB_MISALIGN_CHECK_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int WB_RD_ONLY     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_core_req,
  input  logic                      i_core_we,
  input  logic [ADDR_WIDTH-1:0]     i_core_addr,
  input  logic [DATA_WIDTH-1:0]     i_core_wdata,
  input  logic [2:0]                i_core_funct3,
  output logic [DATA_WIDTH-1:0]     o_core_rdata,
  output logic                      o_core_stall,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      o_sram_csb,
  output logic                      o_sram_web,
  output logic [DATA_WIDTH/8-1:0]   o_sram_wmask,
  output logic [MEM_ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0]     o_sram_din,
  input  logic [DATA_WIDTH-1:0]     i_sram_dout
`ifdef SRAM_ARB_MISALIGN_CHECK_EN
  ,
  output logic                      o_core_misalign
`endif
);

  arb_state_e state_q, state_d;
  logic       wb_busy;
  logic       core_owns;
  logic       core_rd;
  logic       core_mis;
  logic [3:0]  core_wmask;
  logic [31:0] core_din;
  logic        core_st_ok;
  logic        ld_valid_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_lsb_q;
  logic [31:0] ld_data;
  logic [31:0] rdata_q;
  logic        unused_addr_bits;

  // Byte-address bits outside the word index are aliased away on purpose.
  assign unused_addr_bits = ^{i_core_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                              wb_adr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], wb_adr_i[1:0]};

  assign core_owns    = (state_q == IDLE) || (state_q == WB_ACK);
  assign core_rd      = core_owns & i_core_req & ~i_core_we;
  assign o_core_stall = (state_q == WB_ISSUE) || (state_q == WB_DATA);
  assign wb_ack_o     = (state_q == WB_ACK);

  sram_lane_align u_align (
    .st_funct3 (i_core_funct3),
    .st_lsb    (i_core_addr[1:0]),
    .st_wdata  (i_core_wdata),
    .st_wmask  (core_wmask),
    .st_din    (core_din),
    .st_ok     (core_st_ok),
    .ld_funct3 (ld_f3_q),
    .ld_lsb    (ld_lsb_q),
    .ld_dout   (i_sram_dout),
    .ld_data   (ld_data)
  );

`ifdef SRAM_ARB_MISALIGN_CHECK_EN
  logic misalign_q;
  assign core_mis        = is_misaligned(i_core_funct3, i_core_addr[1:0]);
  assign o_core_misalign = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= core_owns & i_core_req & core_mis;
  end
`else
  assign core_mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (wb_cyc_i && wb_stb_i && !wb_busy) state_d = WB_ISSUE;
      WB_ISSUE: state_d = WB_DATA;
      WB_DATA:  state_d = WB_ACK;
      WB_ACK:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    o_sram_csb   = 1'b1;
    o_sram_web   = 1'b1;
    o_sram_wmask = core_wmask;
    o_sram_addr  = i_core_addr[MEM_ADDR_WIDTH+1:2];
    o_sram_din   = core_din;
    if (core_owns) begin
      o_sram_csb = ~i_core_req;
      o_sram_web = ~(i_core_we & core_st_ok & ~core_mis);
    end else if (state_q == WB_ISSUE) begin
      o_sram_csb   = 1'b0;
      o_sram_web   = (WB_RD_ONLY != 0) ? 1'b1 : ~wb_we_i;
      o_sram_wmask = LANE_ALL;
      o_sram_addr  = wb_adr_i[MEM_ADDR_WIDTH+1:2];
      o_sram_din   = wb_dat_i;
    end
  end

  // Output follows the SRAM the cycle after a load, otherwise holds the last result.
  assign o_core_rdata = ld_valid_q ? ld_data : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_busy    <= 1'b0;
      wb_dat_o   <= '0;
      ld_valid_q <= 1'b0;
      ld_f3_q    <= '0;
      ld_lsb_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WB_ACK)  wb_busy <= 1'b1;
      else if (!wb_stb_i)     wb_busy <= 1'b0;
      if ((state_q == WB_DATA) && !wb_we_i) wb_dat_o <= i_sram_dout;
      ld_valid_q <= core_rd;
      if (core_rd) begin
        ld_f3_q  <= i_core_funct3;
        ld_lsb_q <= i_core_addr[1:0];
      end
      if (ld_valid_q) rdata_q <= ld_data;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Single-port SRAM front end, one instance per memory (instruction and data); replaces the open-loop core/UART address muxes.
- Arbitrates the pipeline core port against the UART Wishbone bridge (slave side) and stalls the core while the bridge owns the macro.
- Generates the real Wishbone ack and byte write masks from funct3.
- Returns load data lane-aligned and sign/zero extended for the 1-cycle-latency sky130 SRAM macro.

Parameters:
- DATA_WIDTH, 32, data bus width; must be 32 (funct3 lane logic is RV32).
- ADDR_WIDTH, 32, core and Wishbone byte-address width.
- MEM_ADDR_WIDTH, 9, SRAM word-address width (512 words = 2 KB).
- WB_RD_ONLY, 0, 1 = ignore Wishbone writes: ack them, no SRAM write.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_core_req  in  1  core access valid this cycle
- i_core_we  in  1  core store
- i_core_addr  in  ADDR_WIDTH  core byte address
- i_core_wdata  in  DATA_WIDTH  store data, right-aligned
- i_core_funct3  in  3  RV32 load/store funct3
- o_core_rdata  out  DATA_WIDTH  extended load data, valid cycle after issue
- o_core_stall  out  1  core request this cycle not performed; hold it
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  bridge Wishbone control
- wb_adr_i  in  ADDR_WIDTH  bridge byte address, word-aligned
- wb_dat_i  in  DATA_WIDTH  bridge write data
- wb_dat_o  out  DATA_WIDTH  registered read data to bridge
- wb_ack_o  out  1  single-cycle ack
- o_sram_csb, o_sram_web  out  1 each  active-low chip select / write enable
- o_sram_wmask  out  DATA_WIDTH/8  byte write mask
- o_sram_addr  out  MEM_ADDR_WIDTH  SRAM word address = byte addr[MEM_ADDR_WIDTH+1:2]
- o_sram_din  out  DATA_WIDTH  SRAM write data
- i_sram_dout  in  DATA_WIDTH  SRAM read data, one cycle after issue

Behaviour:
- Reset values:
  - FSM in IDLE.
  - wb_ack_o = 0, wb_dat_o = 0, o_core_stall = 0, o_core_rdata = 0.
  - Lane registers cleared, wb_busy flag cleared.
- IDLE: SRAM port driven combinationally by the core.
  - csb = ~i_core_req; web = ~i_core_we.
  - Core has zero wait states.
- FSM states:
  - IDLE -> WB_ISSUE when wb_cyc_i & wb_stb_i & ~wb_busy. Bridge has priority; the core access in that cycle still completes.
  - WB_ISSUE: SRAM driven from the Wishbone side, wmask all ones. o_core_stall = 1. Next state WB_DATA.
  - WB_DATA: wb_dat_o <= i_sram_dout (reads only). o_core_stall = 1. Next state WB_ACK.
  - WB_ACK: wb_ack_o = 1 for exactly this cycle. Core owns the SRAM again. Set wb_busy. Next state IDLE.
- wb_busy clears when wb_stb_i is low. A stb held across an ack is never served twice.
- Bridge latency: stb to ack = 3 cycles.
- Store mask from funct3 and addr[1:0]:
  - SB: one lane, data replicated to all 4 bytes.
  - SH: lanes {1:0} or {3:2}, data replicated to both halves.
  - SW: all ones.
  - Other funct3 values: no write (web = 1).
- Load path:
  - funct3 and addr[1:0] registered at core issue.
  - Next cycle o_core_rdata = selected lane of i_sram_dout.
  - LB/LH sign-extended; LBU/LHU zero-extended; LW raw.
- o_core_rdata is held during stall cycles. The core's load issued in the IDLE cycle that triggered WB_ISSUE returns normally.
- Reset mid-transaction: return to IDLE, no ack issued, wb_busy cleared.
- Address bits above MEM_ADDR_WIDTH+1 are ignored (alias/wrap).

Optional Feature:
- Macro: SRAM_ARB_MISALIGN_CHECK_EN.
- When defined:
  - Adds output o_core_misalign (1 bit, registered, one cycle after issue).
  - Flags SH/LH/LHU with addr[0] = 1, and SW/LW with addr[1:0] != 0.
  - A misaligned store is suppressed (web = 1).
- When undefined:
  - Port absent.
  - Low address bits are truncated silently; SW/LW use word addr[..:2].

Decomposition:
- Package sram_arb_pkg:
  - funct3 encodings (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5).
  - FSM state encoding (IDLE, WB_ISSUE, WB_DATA, WB_ACK).
  - Lane-mask constants.
- One natural sub-module: sram_lane_align. Combinational; pure funct3/addr-lsb store mask and replication plus load extraction/extension. Unit-testable in isolation.

Test Plan:
- Core SB 0xA5 @ byte addr 0x0000_0006: wmask=0100, din=0xA5A5A5A5, sram addr=1. Then LB @ 0x6 -> o_core_rdata=0xFFFF_FFA5; LBU -> 0x0000_00A5.
- Core SH 0x8001 @ 0x2, then LH @ 0x2 -> 0xFFFF_8001. SW 0xDEADBEEF @ 0x10, then LW @ 0x10 -> 0xDEADBEEF.
- Wishbone write 0x1234_5678 @ 0x20 with core reading every cycle:
  - o_core_stall high exactly 2 cycles.
  - wb_ack_o high 1 cycle, 3 cycles after stb.
  - Following core LW @ 0x20 -> 0x1234_5678.
- Wishbone read @ 0x20 with stb held 4 cycles past ack: exactly one ack, wb_dat_o = 0x1234_5678, no second SRAM access.
- rst asserted in WB_DATA: outputs return to reset values immediately (async); no ack after release.
- SRAM_ARB_MISALIGN_CHECK_EN defined, SW @ 0x3: o_core_misalign=1 next cycle, web held 1, memory unchanged.
